rf_dump: RTL and testbench

Read-side sequencer for the 32x32 three-port register file (`regfile`). It drives the file's two asynchronous read ports to fetch an address range, two registers per fetch, and emits the contents one word at a time on a valid/ready output stream. It is used for debug readback and for scoreboarding the register file in system benches. It is the reader counterpart to the write port driven through `we3`/`wa3`/`wd3`.

---
 rtl/rf_dump.sv | 127 ++++++++++++
 tb/tb_rf_dump.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_dump.sv
// Register-file readback sequencer: fetches a wrapping address range two registers at a time
// and streams the words over valid/ready. Optional trailing XOR word via RF_DUMP_CHECKSUM_EN.
module rf_dump #(
  parameter int NREGS = 32,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic [AW-1:0] first_addr,
  input  logic [AW-1:0] last_addr,
  output logic          busy,
  output logic          done,
  output logic [AW-1:0] ra1,
  output logic [AW-1:0] ra2,
  input  logic [DW-1:0] rd1,
  input  logic [DW-1:0] rd2,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data,
  output logic          out_last
);

  typedef enum logic [1:0] {IDLE, FETCH, DONE} state_t;

  state_t        state, stateNext;
  logic [AW:0]   remain;
  logic [AW:0]   take;
  logic [AW-1:0] span;
  logic [AW-1:0] s0Addr, s1Addr;
  logic [DW-1:0] s0Data, s1Data;
  logic          s0Valid, s1Valid;
  logic          handshake, fetch, regLast, lastWord;

`ifdef RF_DUMP_CHECKSUM_EN
  logic [DW-1:0] csum;
  logic          csumPhase;
`endif

  always_comb begin
    span      = (last_addr - first_addr) & AW'(NREGS - 1);
    handshake = s0Valid & out_ready;
    take      = (remain >= (AW+1)'(2)) ? (AW+1)'(2) : remain;
    // Refill when empty, or when the single held word leaves this cycle.
    fetch     = (state == FETCH) && (remain != '0) && (!s0Valid || (!s1Valid && handshake));
`ifdef RF_DUMP_CHECKSUM_EN
    regLast   = s0Valid & ~s1Valid & (remain == '0) & ~csumPhase;
    lastWord  = s0Valid & csumPhase;
`else
    regLast   = s0Valid & ~s1Valid & (remain == '0);
    lastWord  = regLast;
`endif
    stateNext = state;
    case (state)
      IDLE:    if (start) stateNext = FETCH;
      FETCH:   if (handshake && lastWord) stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign out_valid = s0Valid;
  assign out_addr  = s0Addr;
  assign out_data  = s0Data;
  assign out_last  = lastWord;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      ra1       <= '0;
      ra2       <= '0;
      remain    <= '0;
      s0Addr    <= '0;
      s0Data    <= '0;
      s0Valid   <= 1'b0;
      s1Addr    <= '0;
      s1Data    <= '0;
      s1Valid   <= 1'b0;
`ifdef RF_DUMP_CHECKSUM_EN
      csum      <= '0;
      csumPhase <= 1'b0;
`endif
    end else begin
      state <= stateNext;
      if (state == IDLE && start) begin
        ra1    <= first_addr;
        ra2    <= first_addr + AW'(1);
        remain <= {1'b0, span} + (AW+1)'(1);
`ifdef RF_DUMP_CHECKSUM_EN
        csum      <= '0;
        csumPhase <= 1'b0;
`endif
      end
      if (fetch) begin
        s0Addr  <= ra1;
        s0Data  <= rd1;
        s0Valid <= 1'b1;
        s1Addr  <= ra2;
        s1Data  <= rd2;
        s1Valid <= (remain >= (AW+1)'(2));
        ra1     <= ra1 + AW'(2);
        ra2     <= ra2 + AW'(2);
        remain  <= remain - take;
      end else if (handshake) begin
        s0Addr  <= s1Addr;
        s0Data  <= s1Data;
        s0Valid <= s1Valid;
        s1Valid <= 1'b0;
      end
`ifdef RF_DUMP_CHECKSUM_EN
      if (handshake && !csumPhase) csum <= csum ^ s0Data;
      // The checksum word replaces the final register word in slot0 as it leaves.
      if (handshake && regLast) begin
        s0Addr    <= '0;
        s0Data    <= csum ^ s0Data;
        s0Valid   <= 1'b1;
        csumPhase <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_rf_dump.sv
// Self-checking bench for rf_dump: the bench plays the register file and predicts the
// word stream per dump as a queue built from the range rules.
module tb_rf_dump;
  localparam int AW = 5;
  localparam int DW = 32;
`ifdef RF_DUMP_CHECKSUM_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] first_addr, last_addr;
  logic          busy, done;
  logic [AW-1:0] ra1, ra2;
  logic [DW-1:0] rd1, rd2;
  logic          out_valid, out_ready, out_last;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  logic [DW-1:0] regs [32];
  assign rd1 = regs[ra1];
  assign rd2 = regs[ra2];

  rf_dump #(.NREGS(32), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
    .first_addr(first_addr), .last_addr(last_addr),
    .busy(busy), .done(done), .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } word_t;

  int    checks = 0;
  int    failures = 0;
  word_t expQ[$];
  bit    mBusy = 0, mDone = 0, expValid, wasBusy, newDone;
  int    lat = 0, popped = 0, validCycles = 0, doneSeen = 0;
  int    span, nWords;
  logic [AW-1:0] lastPopAddr, raNext, qa;
  logic [DW-1:0] qx;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference model and compare process, evaluated mid-cycle.
  always @(negedge clk) begin
    if (!reset_n) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", out_valid, 0);
      chk("rst_last", out_last, 0);
      chk("rst_ra1", ra1, 0);
      chk("rst_ra2", ra2, 0);
      chk("rst_addr", out_addr, 0);
      chk("rst_data", out_data, 0);
      expQ.delete();
      mBusy = 0;
      mDone = 0;
      lat = 0;
    end else begin
      expValid = mBusy && lat == 0 && expQ.size() > 0;
      chk("busy", busy, mBusy);
      chk("done", done, mDone);
      chk("out_valid", out_valid, expValid);
      if (mBusy) begin
        raNext = ra1 + 5'd1;
        chk("ra2_pair", ra2, raNext);
      end
      if (out_valid && expQ.size() > 0) begin
        chk("out_addr", out_addr, expQ[0].a);
        chk("out_data", out_data, expQ[0].d);
        chk("out_last", out_last, expQ.size() == 1);
      end
      if (out_valid) validCycles++;
      if (done) doneSeen++;
      wasBusy = mBusy;
      newDone = 0;
      if (out_valid && out_ready && expQ.size() > 0) begin
        newDone = (expQ.size() == 1);
        lastPopAddr = expQ[0].a;
        void'(expQ.pop_front());
        popped++;
      end
      if (mDone) mBusy = 0;
      mDone = newDone;
      if (lat > 0) lat--;
      if (!wasBusy && start) begin
        span = (int'(last_addr) - int'(first_addr) + 32) % 32;
        nWords = span + 1;
        qx = '0;
        for (int i = 0; i < nWords; i++) begin
          qa = 5'((int'(first_addr) + i) % 32);
          expQ.push_back('{a: qa, d: regs[qa]});
          qx = qx ^ regs[qa];
        end
`ifdef RF_DUMP_CHECKSUM_EN
        expQ.push_back('{a: 5'd0, d: qx});
`endif
        mBusy = 1;
        lat = 1;
        popped = 0;
        validCycles = 0;
      end
    end
  end

  task automatic startDump(input logic [AW-1:0] f, input logic [AW-1:0] l);
    @(posedge clk); #1;
    first_addr = f;
    last_addr = l;
    start = 1;
    @(posedge clk); #1;
    start = 0;
    first_addr = AW'($urandom);
    last_addr = AW'($urandom);
  endtask

  // mode 0: ready high; 1: 1,0,0,1,0,1 then high; 2: random ready.
  task automatic drainDump(input int mode, input bit strayStart);
    int cyc = 0;
    int d0 = doneSeen;
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    while (!(doneSeen != d0 && !busy) && cyc < 300) begin
      case (mode)
        0: out_ready = 1;
        1: out_ready = (cyc >= 1 && cyc <= 6) ? pat[cyc-1][0] : 1'b1;
        default: out_ready = ($urandom_range(0, 3) != 0);
      endcase
      if (strayStart && cyc == 3) begin
        start = 1;
        first_addr = AW'($urandom);
        last_addr = AW'($urandom);
      end else begin
        start = 0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 0;
    chk("dump_completes", cyc < 300, 1);
  endtask

  initial begin
    reset_n = 0;
    start = 0;
    first_addr = '0;
    last_addr = '0;
    out_ready = 0;
    for (int i = 0; i < 32; i++) regs[i] = 32'(i * 3);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;

    // Full range, ready held high: 32 words back to back.
    startDump(5'd0, 5'd31);
    chk("full_qsize", expQ.size(), 32 + EXTRA);
    chk("full_q0", expQ[0], {5'd0, 32'd0});
    chk("full_q31", expQ[31], {5'd31, 32'd93});
    drainDump(0, 0);
    chk("full_words", popped, 32 + EXTRA);
    chk("full_valid_cycles", validCycles, 32 + EXTRA);
    chk("full_last_addr", lastPopAddr, (EXTRA != 0) ? 0 : 31);

    // Backpressure on a short range.
    startDump(5'd3, 5'd5);
    chk("bp_q0", expQ[0], {5'd3, 32'd9});
    chk("bp_q2", expQ[2], {5'd5, 32'd15});
    drainDump(1, 0);
    chk("bp_words", popped, 3 + EXTRA);

    // Wrapping range with an even count.
    startDump(5'd30, 5'd1);
    chk("wrap_qsize", expQ.size(), 4 + EXTRA);
    chk("wrap_q1", expQ[1].a, 31);
    chk("wrap_q2", expQ[2].a, 0);
    chk("wrap_q3", expQ[3].a, 1);
    drainDump(0, 0);
    chk("wrap_last_addr", lastPopAddr, (EXTRA != 0) ? 0 : 1);

    // Single-register range.
    startDump(5'd7, 5'd7);
    chk("single_qsize", expQ.size(), 1 + EXTRA);
    chk("single_q0", expQ[0], {5'd7, 32'd21});
    drainDump(2, 0);
    chk("single_words", popped, 1 + EXTRA);

    // A second start while busy is ignored.
    startDump(5'd8, 5'd15);
    drainDump(0, 1);
    chk("stray_words", popped, 8 + EXTRA);
    chk("stray_last_addr", lastPopAddr, (EXTRA != 0) ? 0 : 15);

    // Reset after 5 words leaves no done pulse behind.
    startDump(5'd0, 5'd31);
    out_ready = 1;
    for (int c = 0; c < 100 && popped < 5; c++) begin
      @(posedge clk); #1;
    end
    chk("midrst_progress", popped >= 5, 1);
    #1 reset_n = 0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", out_valid, 0);
    chk("midrst_ra1", ra1, 0);
    chk("midrst_ra2", ra2, 0);
    chk("midrst_done", done, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1;
    repeat (4) @(posedge clk);
    #1;

    // Normal dump after the abort.
    startDump(5'd10, 5'd20);
    drainDump(2, 0);
    chk("post_rst_words", popped, 11 + EXTRA);

`ifdef RF_DUMP_CHECKSUM_EN
    regs[0] = 32'h1; regs[1] = 32'h2; regs[2] = 32'h4; regs[3] = 32'h8;
    startDump(5'd0, 5'd3);
    chk("csum_q4", expQ[4], {5'd0, 32'hF});
    drainDump(0, 0);
    chk("csum_words", popped, 5);
`endif

    // Randomised ranges, contents and backpressure.
    for (int r = 0; r < 12; r++) begin
      int n;
      logic [AW-1:0] f, l;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = AW'($urandom);
      l = AW'($urandom);
      n = ((int'(l) - int'(f) + 32) % 32) + 1 + EXTRA;
      startDump(f, l);
      drainDump(2, 0);
      chk("rand_words", popped, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
